alu_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational 16-bit ALU among NREQ requesters. It accepts one operation per grant over a valid/ready handshake and drives the ALU operand/opcode ports from registers. It captures result and V/N flags, then returns them with the requester ID over a valid/ready response channel. It also keeps a per-requester sticky overflow status for software polling.

---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin scheduler sharing one registered-input 16-bit ALU among NREQ requesters
module alu_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [4*NREQ-1:0]   req_op,
   input  logic [16*NREQ-1:0]  req_a,
   input  logic [16*NREQ-1:0]  req_b,
   output logic [3:0]          alu_op,
   output logic [15:0]         alu_a,
   output logic [15:0]         alu_b,
   input  logic [15:0]         alu_result,
   input  logic                alu_v,
   input  logic                alu_n,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [15:0]         rsp_result,
   output logic                rsp_v,
   output logic                rsp_n,
   output logic [IDW-1:0]      rsp_id,
   output logic [NREQ-1:0]     ovf_sticky,
   input  logic [NREQ-1:0]     ovf_clr,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  cur_id;
   logic [IDW-1:0]  winner;
   logic            found;
   logic [3:0]      win_op;
   logic [15:0]     win_a;
   logic [15:0]     win_b;
   logic [NREQ-1:0] ovf_set;
   int              j;

   // First valid requester at or after rr_ptr, wrapping; rr_ptr is always < NREQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      j      = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_valid[j]) begin
            found  = 1'b1;
            winner = IDW'(j);
            win_op = req_op[j*4 +: 4];
            win_a  = req_a[j*16 +: 16];
            win_b  = req_b[j*16 +: 16];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && found) req_ready[winner] = 1'b1;
   end

   always_comb begin
      ovf_set = '0;
      if (state == EXEC) ovf_set[cur_id] = alu_v;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         cur_id     <= '0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_v      <= 1'b0;
         rsp_n      <= 1'b0;
         rsp_id     <= '0;
         ovf_sticky <= '0;
      end else begin
         // Set beats clear when both hit the same bit.
         ovf_sticky <= (ovf_sticky & ~ovf_clr) | ovf_set;
         case (state)
            IDLE: begin
               if (found) begin
                  alu_op <= win_op;
                  alu_a  <= win_a;
                  alu_b  <= win_b;
                  cur_id <= winner;
                  rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_v      <= alu_v;
               rsp_n      <= alu_n;
               rsp_id     <= cur_id;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a bench-side ALU and reference model
module tb_alu_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_op;
   logic [16*NREQ-1:0] req_a;
   logic [16*NREQ-1:0] req_b;
   logic [3:0]        alu_op;
   logic [15:0]       alu_a;
   logic [15:0]       alu_b;
   logic [15:0]       alu_result;
   logic              alu_v;
   logic              alu_n;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [15:0]       rsp_result;
   logic              rsp_v;
   logic              rsp_n;
   logic [IDW-1:0]    rsp_id;
   logic [NREQ-1:0]   ovf_sticky;
   logic [NREQ-1:0]   ovf_clr;
   logic              busy;

   int vectors = 0;
   int miscompares = 0;
   int model_rr = 0;
   logic [NREQ-1:0] model_sticky = '0;

   logic [20:0] rsp_tuple;
   assign rsp_tuple = {rsp_valid, rsp_result, rsp_v, rsp_n, rsp_id};

   alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_v(alu_v), .alu_n(alu_n),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_v(rsp_v), .rsp_n(rsp_n), .rsp_id(rsp_id),
      .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8..12 pass A, 13..15 zero.
   function automatic logic [17:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      logic        v;
      v = 1'b0;
      case (op)
         4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
         4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: r = a << 1;
         4'd7: r = a >> 1;
         4'd13, 4'd14, 4'd15: r = 16'h0000;
         default: r = a;
      endcase
      return {v, r[15], r};
   endfunction

   always_comb {alu_v, alu_n, alu_result} = alu_ref(alu_op, alu_a, alu_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      req_op[i*4 +: 4]  = op;
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; ovf_clr = '0;
      step();
      rst_n = 1'b1;
      model_rr = 0;
      model_sticky = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rsp_ready = 1'b0; ovf_clr = '0; req_valid = '0;
      for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), 16'($urandom), 16'($urandom));
      step(); step();
      #1;
      vectors++; if ({alu_op, alu_a, alu_b} !== 36'h0) begin miscompares++; $display("FAIL reset_alu: got %h expected 0", {alu_op, alu_a, alu_b}); end
      vectors++; if (rsp_tuple !== 21'h0) begin miscompares++; $display("FAIL reset_rsp: got %h expected 0", rsp_tuple); end
      vectors++; if (ovf_sticky !== 4'h0) begin miscompares++; $display("FAIL reset_sticky: got %b expected 0000", ovf_sticky); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (req_ready !== 4'h0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      rst_n = 1'b1; req_valid = 4'b1010;
      #1;
      vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL reset_ptr: got %b expected 0010", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_single();
      do_reset();
      set_req(1, 4'd0, 16'h7FFF, 16'h0001);
      req_valid = 4'b0010; rsp_ready = 1'b1;
      #1;
      vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
      step();
      req_valid = '0;
      vectors++; if ({alu_op, alu_a, alu_b} !== {4'd0, 16'h7FFF, 16'h0001}) begin miscompares++; $display("FAIL single_alu: got %h expected 07fff0001", {alu_op, alu_a, alu_b}); end
      vectors++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_exec: got busy=%b rsp_valid=%b expected 1 0", busy, rsp_valid); end
      step();
      vectors++; if (rsp_tuple !== {1'b1, 16'h8000, 1'b1, 1'b1, 2'd1}) begin miscompares++; $display("FAIL single_rsp: got %h expected %h", rsp_tuple, {1'b1, 16'h8000, 1'b1, 1'b1, 2'd1}); end
      vectors++; if (ovf_sticky !== 4'b0010) begin miscompares++; $display("FAIL single_sticky: got %b expected 0010", ovf_sticky); end
      step();
      vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rdy;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 4'd1, 16'd5, 16'd3);
      req_valid = 4'hF; rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         exp_rdy = 4'(1 << (g % NREQ));
         #1;
         vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", g, req_ready, exp_rdy); end
         step(); step();
         vectors++; if (rsp_tuple !== {1'b1, 16'h0002, 1'b0, 1'b0, 2'(g % NREQ)}) begin miscompares++; $display("FAIL rr_rsp%0d: got %h expected %h", g, rsp_tuple, {1'b1, 16'h0002, 1'b0, 1'b0, 2'(g % NREQ)}); end
         step();
      end
      req_valid = '0; rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [20:0] exp;
      do_reset();
      set_req(0, 4'd0, 16'h1234, 16'h0101);
      req_valid = 4'b0001; rsp_ready = 1'b0;
      #1;
      step();
      set_req(1, 4'd2, 16'hFFFF, 16'h00F0);
      req_valid = 4'b0011;
      step();
      exp = {1'b1, 16'h1335, 1'b0, 1'b0, 2'd0};
      for (int c = 0; c < 5; c++) begin
         #1;
         vectors++; if (rsp_tuple !== exp || req_ready !== 4'h0 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_hold%0d: got rsp=%h ready=%b busy=%b expected rsp=%h ready=0000 busy=1", c, rsp_tuple, req_ready, busy, exp); end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      vectors++; if (rsp_tuple !== exp || req_ready !== 4'h0) begin miscompares++; $display("FAIL bp_hs: got rsp=%h ready=%b expected rsp=%h ready=0000", rsp_tuple, req_ready, exp); end
      step();
      rsp_ready = 1'b0;
      #1;
      vectors++; if (req_ready !== 4'b0010 || busy !== 1'b0) begin miscompares++; $display("FAIL bp_next: got ready=%b busy=%b expected 0010 0", req_ready, busy); end
      req_valid = '0;
   endtask

   task automatic test_sticky_collision();
      do_reset();
      set_req(2, 4'd0, 16'h7FFF, 16'h0001);
      req_valid = 4'b0100;
      #1;
      step();
      req_valid = '0; ovf_clr = 4'b0100;
      step();
      ovf_clr = '0;
      vectors++; if (ovf_sticky !== 4'b0100 || rsp_v !== 1'b1 || rsp_id !== 2'd2) begin miscompares++; $display("FAIL sticky_collide: got sticky=%b v=%b id=%0d expected 0100 1 2", ovf_sticky, rsp_v, rsp_id); end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      vectors++; if (ovf_sticky !== 4'b0100) begin miscompares++; $display("FAIL sticky_hold: got %b expected 0100", ovf_sticky); end
      ovf_clr = 4'b0100;
      step();
      ovf_clr = '0;
      vectors++; if (ovf_sticky !== 4'b0000) begin miscompares++; $display("FAIL sticky_clear: got %b expected 0000", ovf_sticky); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      set_req(1, 4'd0, 16'h7FFF, 16'h0001);
      set_req(2, 4'd0, 16'h7FFF, 16'h7FFF);
      set_req(0, 4'd4, 16'h00FF, 16'h0F0F);
      set_req(3, 4'd2, 16'hAAAA, 16'hFFFF);
      req_valid = 4'b0010; rsp_ready = 1'b1;
      step();
      req_valid = '0;
      step(); step();
      req_valid = 4'b0100;
      step();
      req_valid = '0; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      vectors++; if ({busy, rsp_tuple, alu_op, alu_a, alu_b, ovf_sticky} !== 62'h0) begin miscompares++; $display("FAIL midrst_state: got busy=%b rsp=%h alu=%h sticky=%b expected all zero", busy, rsp_tuple, {alu_op, alu_a, alu_b}, ovf_sticky); end
      req_valid = 4'b1001;
      #1;
      vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL midrst_ptr: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      step();
      vectors++; if (rsp_tuple !== {1'b1, 16'h0FF0, 1'b0, 1'b0, 2'd0}) begin miscompares++; $display("FAIL midrst_rsp: got %h expected %h", rsp_tuple, {1'b1, 16'h0FF0, 1'b0, 1'b0, 2'd0}); end
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_illegal_op();
      do_reset();
      set_req(2, 4'hF, 16'h1234, 16'($urandom));
      req_valid = 4'b0100; rsp_ready = 1'b1;
      #1;
      step();
      req_valid = '0;
      vectors++; if (alu_op !== 4'hF || alu_a !== 16'h1234) begin miscompares++; $display("FAIL illegal_alu: got op=%h a=%h expected f 1234", alu_op, alu_a); end
      step();
      vectors++; if (rsp_tuple !== {1'b1, 16'h0000, 1'b0, 1'b0, 2'd2}) begin miscompares++; $display("FAIL illegal_rsp: got %h expected %h", rsp_tuple, {1'b1, 16'h0000, 1'b0, 1'b0, 2'd2}); end
      step();
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [3:0]  mask, clr, exp_rdy, w_op;
      logic [15:0] w_a, w_b;
      logic [17:0] res;
      logic [20:0] exp;
      int          w, hold;
      do_reset();
      for (int it = 0; it < 80; it++) begin
         mask = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         clr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), 16'($urandom), 16'($urandom));
         req_valid = mask; ovf_clr = clr; rsp_ready = 1'b0;
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && mask[(model_rr + k) % NREQ]) w = (model_rr + k) % NREQ;
         exp_rdy = (w < 0) ? 4'h0 : 4'(1 << w);
         #1;
         vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL rand_grant it%0d: got %b expected %b", it, req_ready, exp_rdy); end
         if (w >= 0) begin
            w_op = req_op[w*4 +: 4]; w_a = req_a[w*16 +: 16]; w_b = req_b[w*16 +: 16];
            res = alu_ref(w_op, w_a, w_b);
            model_rr = (w + 1) % NREQ;
         end
         step();
         ovf_clr = '0;
         model_sticky = model_sticky & ~clr;
         if (w < 0) begin
            vectors++; if (ovf_sticky !== model_sticky) begin miscompares++; $display("FAIL rand_idle_sticky it%0d: got %b expected %b", it, ovf_sticky, model_sticky); end
            continue;
         end
         for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), 16'($urandom), 16'($urandom));
         req_valid = 4'($urandom);
         #1;
         vectors++; if ({alu_op, alu_a, alu_b, req_ready, busy} !== {w_op, w_a, w_b, 4'h0, 1'b1}) begin miscompares++; $display("FAIL rand_exec it%0d: got %h expected %h", it, {alu_op, alu_a, alu_b, req_ready, busy}, {w_op, w_a, w_b, 4'h0, 1'b1}); end
         step();
         if (res[17]) model_sticky[w] = 1'b1;
         exp = {1'b1, res[15:0], res[17], res[16], 2'(w)};
         vectors++; if (rsp_tuple !== exp || ovf_sticky !== model_sticky) begin miscompares++; $display("FAIL rand_rsp it%0d: got rsp=%h sticky=%b expected rsp=%h sticky=%b", it, rsp_tuple, ovf_sticky, exp, model_sticky); end
         hold = $urandom_range(0, 2);
         for (int c = 0; c < hold; c++) begin
            step();
            vectors++; if (rsp_tuple !== exp || req_ready !== 4'h0) begin miscompares++; $display("FAIL rand_hold it%0d: got rsp=%h ready=%b expected rsp=%h ready=0000", it, rsp_tuple, req_ready, exp); end
         end
         rsp_ready = 1'b1;
         #1;
         vectors++; if (req_ready !== 4'h0) begin miscompares++; $display("FAIL rand_hs_ready it%0d: got %b expected 0000", it, req_ready); end
         step();
         rsp_ready = 1'b0;
         vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rand_done it%0d: got rsp_valid=%b busy=%b expected 0 0", it, rsp_valid, busy); end
      end
      req_valid = '0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; ovf_clr = '0;
      req_op = '0; req_a = '0; req_b = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_sticky_collision();
      test_reset_mid_op();
      test_illegal_op();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
